// File: rtl/mac_pkg.sv
// Shared definitions for the multiplier carry-propagate stage: operand
// widths derived from the mantissa width, and the payload carried
// between the two adder halves.
package mac_pkg;

   localparam int PARM_MANT = 23;
   localparam int W         = 2*PARM_MANT + 3;   // full product word width
   localparam int LO        = PARM_MANT + 1;     // low slice, resolved in stage A
   localparam int HI        = W - LO;            // high slice, resolved in stage B

   // Stage A payload: resolved low slice plus everything stage B still needs.
   typedef struct packed {
      logic [HI-1:0] sum_hi;     // upper sum bits, untouched
      logic [HI-1:0] cs_hi;      // upper bits of the pre-shifted carry word
      logic [LO-1:0] lo_res;     // resolved low slice
      logic          c_lo;       // carry from the low slice into the high slice
      logic          carry_msb;  // carry_i[W-1], weight 2^W after the shift
      logic          sup_sext;   // side-band flag travelling with the beat
   } cpa_beat_t;

   // Stage B payload: the registered output word.
   typedef struct packed {
      logic [W-1:0] result;
      logic         cout;
      logic         sup_sext;
   } cpa_out_t;

endpackage

// File: rtl/mac_cpa_stage_if.sv
// Beat interface between the compression tree, the carry-propagate stage
// and the normalisation logic. Names are from the stage's point of view.
//
// Handshake: a beat moves across a boundary on a rising edge where its
// valid and the receiver's ready are both high. A sender holding valid
// keeps its payload stable until that edge; ready may depend
// combinationally on the receiver's own ready, never on the sender's valid.
interface mac_cpa_stage_if #(
   parameter int W = mac_pkg::W
);

   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] sum_i;
   logic [W-1:0] carry_i;
   logic         sup_sext_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] result_o;
   logic         cout_o;
   logic         sup_sext_o;

   // The stage itself.
   modport slave (
      input  valid_i, sum_i, carry_i, sup_sext_i, ready_i,
      output ready_o, valid_o, result_o, cout_o, sup_sext_o
   );

   // The surrounding datapath (tree upstream, normaliser downstream).
   modport master (
      output valid_i, sum_i, carry_i, sup_sext_i, ready_i,
      input  ready_o, valid_o, result_o, cout_o, sup_sext_o
   );

endinterface

// File: rtl/mac_cpa_stage_cpa_slice.sv
// Plain parameterised ripple/inferred adder used for both halves of the
// carry-propagate addition.
module cpa_slice #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] full;

   // One extra bit of precision captures the carry out.
   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      s    = full[WIDTH-1:0];
      cout = full[WIDTH];
   end

endmodule

// File: rtl/mac_cpa_stage.sv
// Two-stage carry-propagate adder resolving the Wallace tree's redundant
// sum/carry pair into one binary word. Stage A adds the low slice, stage B
// adds the high slice with the low-slice carry. Each stage has its own
// valid bit; the ready chain gives full throughput and full backpressure.
module mac_cpa_stage
   import mac_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           flush_i,
   mac_cpa_stage_if.slave cpa
);

   logic [W-1:0]  cs;
   logic [LO-1:0] lo_sum;
   logic          lo_cout;
   logic [HI-1:0] hi_sum;
   logic          hi_cout;

   logic          ready_a;
   logic          ready_b;
   logic          accept_a;
   logic          adv_b;

   logic          valid_a_d, valid_a_q;
   logic          valid_b_d, valid_b_q;
   cpa_beat_t     beat_a_d, beat_a_q;
   cpa_out_t      out_b_d, out_b_q;

   // Low slice: resolved straight from the input operands.
   cpa_slice #(.WIDTH(LO)) u_lo (
      .a    (cpa.sum_i[LO-1:0]),
      .b    (cs[LO-1:0]),
      .cin  (1'b0),
      .s    (lo_sum),
      .cout (lo_cout)
   );

   // High slice: resolved from the stage A registers.
   cpa_slice #(.WIDTH(HI)) u_hi (
      .a    (beat_a_q.sum_hi),
      .b    (beat_a_q.cs_hi),
      .cin  (beat_a_q.c_lo),
      .s    (hi_sum),
      .cout (hi_cout)
   );

   // Carry alignment and the ready/transfer chain; flush wins over any transfer.
   always_comb begin
      cs       = {cpa.carry_i[W-2:0], 1'b0};
      ready_b  = !valid_b_q || cpa.ready_i;
      ready_a  = flush_i || !valid_a_q || ready_b;
      accept_a = cpa.valid_i && ready_a && !flush_i;
      adv_b    = valid_a_q && ready_b && !flush_i;
   end

   // Next-state for valids and payloads; payloads only move on a transfer.
   always_comb begin
      valid_a_d = valid_a_q;
      valid_b_d = valid_b_q;
      beat_a_d  = beat_a_q;
      out_b_d   = out_b_q;

      if (flush_i) begin
         valid_a_d = 1'b0;
         valid_b_d = 1'b0;
      end else begin
         if (accept_a) begin
            valid_a_d = 1'b1;
         end else if (adv_b) begin
            valid_a_d = 1'b0;
         end
         if (adv_b) begin
            valid_b_d = 1'b1;
         end else if (cpa.ready_i) begin
            valid_b_d = 1'b0;
         end
      end

      if (accept_a) begin
         beat_a_d.sum_hi    = cpa.sum_i[W-1:LO];
         beat_a_d.cs_hi     = cs[W-1:LO];
         beat_a_d.lo_res    = lo_sum;
         beat_a_d.c_lo      = lo_cout;
         beat_a_d.carry_msb = cpa.carry_i[W-1];
         beat_a_d.sup_sext  = cpa.sup_sext_i;
      end

      // carry_msb and the high-slice carry both carry weight 2^W; a valid
      // tree never sets both, so OR-ing them gives bit W of the true sum.
      if (adv_b) begin
         out_b_d.result   = {hi_sum, beat_a_q.lo_res};
         out_b_d.cout     = hi_cout | beat_a_q.carry_msb;
         out_b_d.sup_sext = beat_a_q.sup_sext;
      end
   end

   // Pipeline registers; reset discards any beats in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         beat_a_q  <= '0;
         out_b_q   <= '0;
      end else begin
         valid_a_q <= valid_a_d;
         valid_b_q <= valid_b_d;
         beat_a_q  <= beat_a_d;
         out_b_q   <= out_b_d;
      end
   end

   assign cpa.ready_o    = ready_a;
   assign cpa.valid_o    = valid_b_q;
   assign cpa.result_o   = out_b_q.result;
   assign cpa.cout_o     = out_b_q.cout;
   assign cpa.sup_sext_o = out_b_q.sup_sext;

endmodule

// File: tb/tb_mac_cpa_stage.sv
// Directed and random bench for mac_cpa_stage. Inputs change 1 time unit
// after a rising edge; outputs are sampled on the falling edge.
module tb_mac_cpa_stage;
   import mac_pkg::*;

   localparam int QW = W + 2;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic flush_i;

   mac_cpa_stage_if #(.W(W)) cpa ();

   mac_cpa_stage dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .cpa     (cpa)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- bookkeeping ----------------
   int              n_checks = 0;
   int              n_errors = 0;
   int              n_out    = 0;
   logic [QW-1:0]   exp_q[$];
   logic [W-1:0]    got_q[$];
   bit              rand_done = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: bit-exact sum + 2*carry with one extra bit for the carry out.
   function automatic logic [QW-1:0] model(input logic [W-1:0] s, input logic [W-1:0] c,
                                           input logic sup);
      logic [W:0] full;
      full = {1'b0, s} + {c, 1'b0};
      return {sup, full[W], full[W-1:0]};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic         hold_vld = 1'b0;
   logic [W-1:0] hold_res;
   logic         hold_cout;
   logic         hold_sup;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (hold_vld && cpa.valid_o) begin
            check_val("stall_result", 64'(cpa.result_o), 64'(hold_res));
            check_val("stall_cout", 64'(cpa.cout_o), 64'(hold_cout));
            check_val("stall_sup", 64'(cpa.sup_sext_o), 64'(hold_sup));
         end
         if (cpa.valid_o && cpa.ready_i) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_beat", 64'(cpa.valid_o), 64'(0));
            end else begin
               logic [QW-1:0] e;
               e = exp_q.pop_front();
               check_val("sb_result", 64'(cpa.result_o), 64'(e[W-1:0]));
               check_val("sb_cout", 64'(cpa.cout_o), 64'(e[W]));
               check_val("sb_sup", 64'(cpa.sup_sext_o), 64'(e[W+1]));
               got_q.push_back(cpa.result_o);
               n_out++;
            end
         end
         hold_vld  = cpa.valid_o && !cpa.ready_i;
         hold_res  = cpa.result_o;
         hold_cout = cpa.cout_o;
         hold_sup  = cpa.sup_sext_o;
      end else begin
         hold_vld = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic align();
      @(posedge clk_i);
      #1;
   endtask

   // Present one beat and hold it until accepted; records the expectation.
   task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic sup);
      int waited;
      waited         = 0;
      cpa.valid_i    = 1'b1;
      cpa.sum_i      = s;
      cpa.carry_i    = c;
      cpa.sup_sext_i = sup;
      @(negedge clk_i);
      while (!cpa.ready_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      if (!cpa.ready_o) check_val("send_timeout", 64'(cpa.ready_o), 64'(1));
      else exp_q.push_back(model(s, c, sup));
      align();
   endtask

   // After a single accepted beat: checks 2-cycle latency and one-cycle valid.
   task automatic check_single(input string tag, input logic [W-1:0] res,
                               input logic cout, input logic sup);
      cpa.valid_i = 1'b0;
      @(negedge clk_i);
      check_val({tag, "_early"}, 64'(cpa.valid_o), 64'(0));
      @(negedge clk_i);
      check_val({tag, "_valid"}, 64'(cpa.valid_o), 64'(1));
      check_val({tag, "_result"}, 64'(cpa.result_o), 64'(res));
      check_val({tag, "_cout"}, 64'(cpa.cout_o), 64'(cout));
      check_val({tag, "_sup"}, 64'(cpa.sup_sext_o), 64'(sup));
      @(negedge clk_i);
      check_val({tag, "_one_cycle"}, 64'(cpa.valid_o), 64'(0));
      align();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] all_ones;
      logic [W-1:0] msb_only;
      int           base;
      int           w;

      all_ones         = '1;
      msb_only         = '0;
      msb_only[W-1]    = 1'b1;

      rst_ni           = 1'b0;
      flush_i          = 1'b0;
      cpa.valid_i      = 1'b0;
      cpa.sum_i        = '0;
      cpa.carry_i      = '0;
      cpa.sup_sext_i   = 1'b0;
      cpa.ready_i      = 1'b1;

      // Reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_val("rst_valid_o", 64'(cpa.valid_o), 64'(0));
      check_val("rst_result_o", 64'(cpa.result_o), 64'(0));
      check_val("rst_cout_o", 64'(cpa.cout_o), 64'(0));
      check_val("rst_sup_o", 64'(cpa.sup_sext_o), 64'(0));
      align();
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_val("rel_ready_o", 64'(cpa.ready_o), 64'(1));
      align();

      // Basic, cross-slice carry, full wrap, carry MSB weight 2^W
      send(49'd1, 49'd0, 1'b0);
      check_single("basic", 49'd1, 1'b0, 1'b0);
      send(49'hFF_FFFF, 49'd1, 1'b0);
      check_single("xslice", 49'h100_0001, 1'b0, 1'b0);
      send(all_ones, 49'd1, 1'b1);
      check_single("wrap", 49'd1, 1'b1, 1'b1);
      send(49'd5, msb_only, 1'b0);
      check_single("cmsb", 49'd5, 1'b1, 1'b0);

      // Backpressure: four back-to-back beats, ready_i low for three cycles
      got_q.delete();
      fork
         begin
            send(49'd8, 49'd1, 1'b0);    // 10
            send(49'd0, 49'd10, 1'b0);   // 20
            send(49'd30, 49'd0, 1'b1);   // 30
            send(49'd36, 49'd2, 1'b0);   // 40
            cpa.valid_i = 1'b0;
         end
         begin
            repeat (2) @(posedge clk_i);
            #1;
            cpa.ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk_i);
               check_val("bp_ready_o_low", 64'(cpa.ready_o), 64'(0));
               align();
            end
            cpa.ready_i = 1'b1;
         end
      join
      repeat (6) align();
      check_val("bp_drained", 64'(exp_q.size()), 64'(0));
      check_val("bp_count", 64'(got_q.size()), 64'(4));
      if (got_q.size() == 4) begin
         check_val("bp_out0", 64'(got_q[0]), 64'(10));
         check_val("bp_out1", 64'(got_q[1]), 64'(20));
         check_val("bp_out2", 64'(got_q[2]), 64'(30));
         check_val("bp_out3", 64'(got_q[3]), 64'(40));
      end

      // Flush with both stages full and a beat presented alongside it
      cpa.ready_i = 1'b0;
      send(49'd100, 49'd0, 1'b0);
      send(49'd200, 49'd0, 1'b0);
      cpa.valid_i = 1'b1;
      cpa.sum_i   = 49'd300;
      cpa.carry_i = '0;
      flush_i     = 1'b1;
      @(negedge clk_i);
      check_val("flush_ready_o", 64'(cpa.ready_o), 64'(1));
      exp_q.delete();
      align();
      flush_i     = 1'b0;
      cpa.valid_i = 1'b0;
      cpa.ready_i = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         check_val("flush_no_valid", 64'(cpa.valid_o), 64'(0));
      end
      align();
      send(49'd7, 49'd3, 1'b0);
      check_single("post_flush", 49'd13, 1'b0, 1'b0);

      // Asynchronous reset with both stages full
      cpa.ready_i = 1'b0;
      send(49'd11, 49'd0, 1'b1);
      send(49'd22, 49'd0, 1'b1);
      cpa.valid_i = 1'b0;
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check_val("arst_valid_o", 64'(cpa.valid_o), 64'(0));
      check_val("arst_result_o", 64'(cpa.result_o), 64'(0));
      check_val("arst_cout_o", 64'(cpa.cout_o), 64'(0));
      check_val("arst_sup_o", 64'(cpa.sup_sext_o), 64'(0));
      exp_q.delete();
      align();
      align();
      rst_ni      = 1'b1;
      cpa.ready_i = 1'b1;
      @(negedge clk_i);
      check_val("arst_rel_ready_o", 64'(cpa.ready_o), 64'(1));
      check_val("arst_rel_valid_o", 64'(cpa.valid_o), 64'(0));
      align();

      // Random run against the reference model with random backpressure
      base = n_out;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [63:0]  r_s;
               logic [63:0]  r_c;
               logic [W-1:0] c;
               r_s      = {$urandom(), $urandom()};
               r_c      = {$urandom(), $urandom()};
               c        = r_c[W-1:0];
               c[W-1]   = 1'b0;
               send(r_s[W-1:0], c, 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) begin
                  cpa.valid_i = 1'b0;
                  align();
               end
            end
            cpa.valid_i = 1'b0;
            rand_done   = 1'b1;
         end
         begin
            while (!rand_done) begin
               cpa.ready_i = ($urandom_range(0, 3) != 0);
               align();
            end
            cpa.ready_i = 1'b1;
         end
      join
      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         align();
         w++;
      end
      check_val("rand_drained", 64'(exp_q.size()), 64'(0));
      check_val("rand_count", 64'(n_out - base), 64'(1000));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
